// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// The controller splits each 32-bit access into two 16-bit SRAM phases.
package sram_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int CNT_W   = 8;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Bundle for the pipeline side (request/ready/load data) and the external SRAM pins.
// The slave modport is the controller; the master modport is the pipeline/SRAM side.
interface sram_mem_ctrl_if;
    import sram_mem_ctrl_pkg::*;

    logic               mem_r_en;
    logic               mem_w_en;
    logic [31:0]        alu_res;
    logic [31:0]        val_rm;
    logic               ready;
    logic [31:0]        read_data;
    logic [SRAM_AW-1:0] sram_addr;
    logic [SRAM_DW-1:0] sram_dq_out;
    logic [SRAM_DW-1:0] sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    modport slave (
        input  mem_r_en, mem_w_en, alu_res, val_rm, sram_dq_in,
        output ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output mem_r_en, mem_w_en, alu_res, val_rm, sram_dq_in,
        input  ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage memory controller: one 32-bit load/store becomes a low then a high
// halfword SRAM phase, each ACCESS_CYCLES long, with ready low while busy.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = BASE_ADDR_DEFAULT,
    parameter int          ACCESS_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    sram_mem_ctrl_if.slave bus
);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        data_q;
    logic               write_q;
    logic [SRAM_DW-1:0] low_q;
    logic               request;
    logic               last_cycle;
    logic               pre_last;
    logic [SRAM_AW-2:0] word_in;

    assign request    = bus.mem_r_en | bus.mem_w_en;
    assign last_cycle = (cnt == CNT_W'(ACCESS_CYCLES - 1));
    assign pre_last   = (cnt == CNT_W'(ACCESS_CYCLES - 2));
    assign word_in    = (SRAM_AW-1)'((bus.alu_res - BASE_ADDR) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (request) next_state = LOW;
            LOW:     if (last_cycle) next_state = HIGH;
            HIGH:    if (last_cycle) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ready is combinational in IDLE so the freeze hits in the request cycle
    always_comb begin
        bus.ready = 1'b0;
        case (state)
            IDLE:    bus.ready = !request;
            DONE:    bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    // SRAM pins are loaded one cycle ahead of each phase so they stay stable
    // for the whole phase; we_n rises one cycle before the phase ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            word_q          <= '0;
            data_q          <= '0;
            write_q         <= 1'b0;
            low_q           <= '0;
            bus.read_data   <= '0;
            bus.sram_addr   <= '0;
            bus.sram_dq_out <= '0;
            bus.sram_dq_oe  <= 1'b0;
            bus.sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        word_q          <= word_in;
                        data_q          <= bus.val_rm;
                        write_q         <= bus.mem_w_en;
                        cnt             <= '0;
                        bus.sram_addr   <= {word_in, 1'b0};
                        bus.sram_dq_out <= bus.val_rm[15:0];
                        bus.sram_dq_oe  <= bus.mem_w_en;
                        bus.sram_we_n   <= !bus.mem_w_en;
                    end
                end
                LOW: begin
                    if (last_cycle) begin
                        cnt             <= '0;
                        if (!write_q) low_q <= bus.sram_dq_in;
                        bus.sram_addr   <= {word_q, 1'b1};
                        bus.sram_dq_out <= data_q[31:16];
                        bus.sram_we_n   <= !write_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (pre_last) bus.sram_we_n <= 1'b1;
                    end
                end
                HIGH: begin
                    if (last_cycle) begin
                        cnt            <= '0;
                        if (!write_q) bus.read_data <= {bus.sram_dq_in, low_q};
                        bus.sram_dq_oe <= 1'b0;
                        bus.sram_we_n  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (pre_last) bus.sram_we_n <= 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: directed accesses against a cycle-count
// model of the access timeline, plus literal expectations on selected cycles.
module tb_sram_mem_ctrl;

    localparam int          AC   = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sram_mem_ctrl_if bus();

    sram_mem_ctrl #(
        .BASE_ADDR     (BASE),
        .ACCESS_CYCLES (AC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench SRAM: asynchronous read, written on a clock edge while we_n is low
    logic [15:0] sram [0:1023] = '{2: 16'h5678, 3: 16'h1234, default: 16'h0000};
    assign bus.sram_dq_in = sram[bus.sram_addr[9:0]];

    always @(posedge clk) begin
        if (bus.sram_dq_oe && !bus.sram_we_n) sram[bus.sram_addr[9:0]] = bus.sram_dq_out;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted request occupies cycles k = 1..2*AC (phases)
    // and k = 2*AC+1 (completion); memory contents follow completed stores.
    logic [15:0] ref_mem [0:1023] = '{2: 16'h5678, 3: 16'h1234, default: 16'h0000};
    bit          m_busy  = 0;
    int          m_k     = 0;
    bit          m_write = 0;
    logic [16:0] m_word  = '0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_rd    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_k    = 0;
            m_rd   = '0;
        end else if (!m_busy) begin
            if (bus.mem_r_en || bus.mem_w_en) begin
                m_busy  = 1;
                m_k     = 1;
                m_write = bus.mem_w_en;
                m_word  = 17'((bus.alu_res - BASE) >> 2);
                m_data  = bus.val_rm;
            end
        end else if (m_k == 2*AC+1) begin
            m_busy = 0;
        end else begin
            m_k++;
            if (m_k == 2*AC+1) begin
                if (m_write) begin
                    ref_mem[int'(m_word)*2]   = m_data[15:0];
                    ref_mem[int'(m_word)*2+1] = m_data[31:16];
                end else begin
                    m_rd = {ref_mem[int'(m_word)*2+1], ref_mem[int'(m_word)*2]};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic        exp_ready;
            logic        in_low;
            int          pi;
            exp_ready = m_busy ? (m_k == 2*AC+1) : !(bus.mem_r_en || bus.mem_w_en);
            check_output("ready", 32'(bus.ready), 32'(exp_ready));
            check_output("read_data", bus.read_data, m_rd);
            if (m_busy && m_k <= 2*AC) begin
                in_low = (m_k <= AC);
                pi     = in_low ? m_k : m_k - AC;
                check_output("sram_addr", 32'(bus.sram_addr), 32'({m_word, !in_low}));
                check_output("dq_oe", 32'(bus.sram_dq_oe), 32'(m_write));
                check_output("we_n", 32'(bus.sram_we_n), 32'(m_write ? (pi == AC) : 1'b1));
                if (m_write)
                    check_output("dq_out", 32'(bus.sram_dq_out),
                                 32'(in_low ? m_data[15:0] : m_data[31:16]));
            end else begin
                check_output("dq_oe_idle", 32'(bus.sram_dq_oe), 32'd0);
                check_output("we_n_idle", 32'(bus.sram_we_n), 32'd1);
            end
        end
    end

    logic [17:0] tr_addr [0:19];
    logic [15:0] tr_dq   [0:19];
    logic        tr_we   [0:19];
    logic        tr_oe   [0:19];
    int          stall;

    // Presents one request, then scrambles the inputs once it is accepted and
    // records the SRAM pins on every stalled cycle until ready returns.
    task automatic apply_stimulus(input logic r, input logic w,
                                  input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        bus.mem_r_en = r;
        bus.mem_w_en = w;
        bus.alu_res  = addr;
        bus.val_rm   = data;
        stall = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && stall < 20) begin
            tr_addr[stall] = bus.sram_addr;
            tr_dq[stall]   = bus.sram_dq_out;
            tr_we[stall]   = bus.sram_we_n;
            tr_oe[stall]   = bus.sram_dq_oe;
            stall++;
            @(posedge clk);
            #1;
            bus.mem_r_en = 1'b0;
            bus.mem_w_en = 1'b0;
            bus.alu_res  = 32'd0;
            bus.val_rm   = 32'd0;
            @(negedge clk);
        end
        check_output("stall_cycles", 32'(stall), 32'd5);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst          = 1'b1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.alu_res  = 32'd0;
        bus.val_rm   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] idle");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("idle_ready", 32'(bus.ready), 32'd1);
            check_output("idle_read_data", bus.read_data, 32'd0);
        end

        $display("[TB] store 0xDEADBEEF to 1024");
        apply_stimulus(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        check_output("st_addr_lo", 32'(tr_addr[1]), 32'd0);
        check_output("st_dq_lo", 32'(tr_dq[1]), 32'h0000BEEF);
        check_output("st_we_lo1", 32'(tr_we[1]), 32'd0);
        check_output("st_we_lo2", 32'(tr_we[2]), 32'd1);
        check_output("st_addr_hi", 32'(tr_addr[3]), 32'd1);
        check_output("st_dq_hi", 32'(tr_dq[3]), 32'h0000DEAD);
        check_output("st_we_hi1", 32'(tr_we[3]), 32'd0);
        check_output("st_we_hi2", 32'(tr_we[4]), 32'd1);

        $display("[TB] load from 1028");
        apply_stimulus(1'b1, 1'b0, 32'd1028, 32'd0);
        check_output("ld_addr_lo", 32'(tr_addr[1]), 32'd2);
        check_output("ld_addr_hi", 32'(tr_addr[3]), 32'd3);
        check_output("ld_oe", 32'(tr_oe[2] | tr_oe[4]), 32'd0);
        check_output("ld_data", bus.read_data, 32'h12345678);

        $display("[TB] both enables at 2048");
        apply_stimulus(1'b1, 1'b1, 32'd2048, 32'hCAFEF00D);
        check_output("prio_addr_lo", 32'(tr_addr[1]), 32'd512);
        check_output("prio_addr_hi", 32'(tr_addr[3]), 32'd513);
        check_output("prio_oe", 32'(tr_oe[1]), 32'd1);
        check_output("ld_data_held", bus.read_data, 32'h12345678);

        apply_stimulus(1'b1, 1'b0, 32'd2048, 32'd0);
        check_output("readback", bus.read_data, 32'hCAFEF00D);

        $display("[TB] reset during high phase of a store");
        @(posedge clk);
        #1;
        bus.mem_w_en = 1'b1;
        bus.alu_res  = 32'd1424;
        bus.val_rm   = 32'h11112222;
        @(posedge clk);
        #1;
        bus.mem_w_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("pre_reset_addr", 32'(bus.sram_addr), 32'd201);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_ready", 32'(bus.ready), 32'd1);
        check_output("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        check_output("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
        check_output("rst_read_data", bus.read_data, 32'd0);

        apply_stimulus(1'b1, 1'b0, 32'd1028, 32'd0);
        check_output("recover_load", bus.read_data, 32'h12345678);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
